axi_wr_ctrl: RTL and testbench

AXI_WR_CTRL -- requirements
Module: axi_wr_ctrl

---
 rtl/axi_wr_ctrl.sv | 145 ++++++++++++++
 tb/tb_axi_wr_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_ctrl.sv
// AXI write-burst controller: turns a rising edge on wr_req into one AW handshake
// followed by awlen+1 W beats taken from a show-ahead user FIFO.
module axi_wr_ctrl #(
  localparam int CTRL_ADDR_WIDTH = 28,
  localparam int MEM_DQ_WIDTH    = 32,
  localparam int DATA_WIDTH      = MEM_DQ_WIDTH * 8
) (
  input  logic                       clk_100M,
  input  logic                       rstn,
  input  logic                       init_done,
  input  logic                       wr_req,
  input  logic [CTRL_ADDR_WIDTH-1:0] wr_addr,
  input  logic [3:0]                 awlen,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_data_req,
  output logic                       wr_busy,
  output logic                       wr_done,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [3:0]                 axi_awlen,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [DATA_WIDTH-1:0]      axi_wdata,
  output logic [DATA_WIDTH/8-1:0]    axi_wstrb,
  output logic                       axi_wvalid,
  output logic                       axi_wlast,
  input  logic                       axi_wready
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_SHAKE = 4'b0010,
    S_WRITE = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t                     state_q, state_d;
  logic                       wr_req_d_q;
  logic                       arm_q;
  logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [3:0]                 awlen_q, awlen_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       rise;
  logic                       beat_ok;
  logic                       last_beat;

  // arm_q blocks a level that was already high when reset released from looking like a rise
  assign rise      = wr_req & ~wr_req_d_q & arm_q;
  assign beat_ok   = wvalid_q & axi_wready;
  assign last_beat = wvalid_q & (cnt_q == awlen_q);

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rise && init_done) begin
          state_d   = S_SHAKE;
          awaddr_d  = wr_addr;
          awlen_d   = awlen;
          awvalid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_SHAKE: begin
        if (awvalid_q && axi_awready) begin
          state_d   = S_WRITE;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          cnt_d     = 4'd0;
        end
      end
      S_WRITE: begin
        // the counter stops on the last beat so awlen=15 never wraps it
        if (beat_ok) begin
          if (last_beat) begin
            state_d  = S_DONE;
            wvalid_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_100M or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wr_req_d_q <= 1'b0;
      arm_q      <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_req_d_q <= wr_req;
      arm_q      <= arm_q | ~wr_req;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wlast   = last_beat;
  assign axi_wdata   = wr_data;
  assign axi_wstrb   = '1;
  assign wr_data_req = beat_ok;
  assign wr_busy     = busy_q;
  assign wr_done     = done_q;

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Bench for axi_wr_ctrl: directed and randomized bursts checked against a
// transaction-level model of the expected AW/W traffic.
module tb_axi_wr_ctrl;

  logic         clk_100M = 1'b0;
  logic         rstn;
  logic         init_done;
  logic         wr_req;
  logic [27:0]  wr_addr;
  logic [3:0]   awlen;
  logic [255:0] wr_data;
  logic         wr_data_req;
  logic         wr_busy;
  logic         wr_done;
  logic [27:0]  axi_awaddr;
  logic [3:0]   axi_awlen;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wvalid;
  logic         axi_wlast;
  logic         axi_wready;

  axi_wr_ctrl dut (
    .clk_100M   (clk_100M),
    .rstn       (rstn),
    .init_done  (init_done),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .awlen      (awlen),
    .wr_data    (wr_data),
    .wr_data_req(wr_data_req),
    .wr_busy    (wr_busy),
    .wr_done    (wr_done),
    .axi_awaddr (axi_awaddr),
    .axi_awlen  (axi_awlen),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wvalid (axi_wvalid),
    .axi_wlast  (axi_wlast),
    .axi_wready (axi_wready)
  );

  always #5 clk_100M = ~clk_100M;

  int checks = 0;
  int errors = 0;

  logic [255:0] src [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awaddr"},  axi_awaddr,  0);
    chk({tag, "_awlen"},   axi_awlen,   0);
    chk({tag, "_awvalid"}, axi_awvalid, 0);
    chk({tag, "_wvalid"},  axi_wvalid,  0);
    chk({tag, "_wlast"},   axi_wlast,   0);
    chk({tag, "_busy"},    wr_busy,     0);
    chk({tag, "_done"},    wr_done,     0);
    chk({tag, "_datareq"}, wr_data_req, 0);
    chk({tag, "_wstrb"},   axi_wstrb,   64'hFFFF_FFFF);
  endtask

  // wmode: 0 wready tied high, 1 toggles every cycle, 2 random (mostly high)
  // abort_beats > 0: assert reset once that many beats have been accepted
  task automatic run_burst(input string tag, input logic [27:0] addr, input logic [3:0] len,
                           input int aw_delay, input int wmode, input bit second_rise,
                           input int abort_beats);
    int aw_cycles = 0, aw_hs = 0, aw_bad = 0, beats = 0, data_bad = 0;
    int wlast_cnt = 0, wlast_bad = 0, req_cnt = 0, req_bad = 0, early_w = 0;
    int done_cnt = 0, busy_bad = 0, src_idx = 0, tail = -1, cyc;
    bit hs_done = 0, done_seen = 0, req_seen;
    logic [27:0] hs_addr = '0;
    logic [3:0]  hs_len = '0;
    for (int i = 0; i < 16; i++) src[i] = {8{$urandom()}};
    @(posedge clk_100M); #1;
    wr_req = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
    @(posedge clk_100M); #1;
    wr_req = 1'b1; wr_addr = addr; awlen = len; wr_data = src[0];
    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_100M);
      if (axi_awvalid) begin
        aw_cycles++;
        if (axi_awaddr !== addr || axi_awlen !== len) aw_bad++;
      end
      if (axi_awvalid && axi_awready) begin
        aw_hs++; hs_addr = axi_awaddr; hs_len = axi_awlen;
      end
      if (axi_wvalid && !hs_done) early_w++;
      if (axi_wvalid) begin
        if (axi_wlast !== (beats == int'(len))) wlast_bad++;
      end else if (axi_wlast) wlast_bad++;
      if (axi_wvalid && axi_wready) begin
        if (beats > 15 || axi_wdata !== src[beats]) data_bad++;
        if (axi_wlast) wlast_cnt++;
        beats++;
      end
      req_seen = wr_data_req;
      if (wr_data_req) req_cnt++;
      if (wr_data_req && !(axi_wvalid && axi_wready)) req_bad++;
      if ((axi_awvalid || axi_wvalid) && !wr_busy) busy_bad++;
      if (done_seen && wr_busy) busy_bad++;
      if (wr_done) begin done_cnt++; done_seen = 1; end
      if (axi_awvalid && axi_awready) hs_done = 1;
      if (abort_beats > 0 && beats == abort_beats) begin
        #2 rstn = 1'b0;
        #1 chk_all_zero({tag, "_midrst"});
        return;
      end
      if (wr_done && tail < 0) tail = 3;
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(posedge clk_100M); #1;
      axi_awready = (aw_cycles >= aw_delay);
      case (wmode)
        0: axi_wready = 1'b1;
        1: axi_wready = ~axi_wready;
        default: axi_wready = ($urandom_range(0, 3) != 0);
      endcase
      if (req_seen) src_idx++;
      wr_data = src[(src_idx > 15) ? 15 : src_idx];
      if (aw_cycles > 0) begin wr_addr = 28'($urandom()); awlen = 4'($urandom()); end
      if (second_rise && cyc == 3) wr_req = 1'b0;
      if (second_rise && cyc == 4) wr_req = 1'b1;
    end
    wr_req = 1'b0;
    chk({tag, "_no_timeout"}, (cyc < 300), 1);
    chk({tag, "_aw_handshakes"}, aw_hs, 1);
    chk({tag, "_awaddr"}, hs_addr, addr);
    chk({tag, "_awlen"}, hs_len, len);
    chk({tag, "_awvalid_cycles"}, aw_cycles, aw_delay + 1);
    chk({tag, "_aw_stable"}, aw_bad, 0);
    chk({tag, "_early_wvalid"}, early_w, 0);
    chk({tag, "_beats"}, beats, int'(len) + 1);
    chk({tag, "_beat_data"}, data_bad, 0);
    chk({tag, "_wlast_count"}, wlast_cnt, 1);
    chk({tag, "_wlast_timing"}, wlast_bad, 0);
    chk({tag, "_datareq_pulses"}, req_cnt, int'(len) + 1);
    chk({tag, "_datareq_in_stall"}, req_bad, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    int bad;
    rstn = 1'b1; init_done = 1'b0; wr_req = 1'b0; wr_addr = '0; awlen = '0;
    wr_data = '0; axi_awready = 1'b0; axi_wready = 1'b0;
    #3 rstn = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk_100M);
    #1 rstn = 1'b1;
    init_done = 1'b1;

    run_burst("basic", 28'h0001000, 4'd3, 0, 0, 1'b0, 0);
    run_burst("awdelay", 28'($urandom()), 4'd0, 5, 0, 1'b0, 0);
    run_burst("wtoggle", 28'($urandom()), 4'd7, 0, 1, 1'b0, 0);

    // a rise without calibration is dropped and is not replayed later
    @(posedge clk_100M); #1;
    init_done = 1'b0; wr_req = 1'b0;
    @(posedge clk_100M); #1;
    wr_req = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk_100M);
      if (axi_awvalid || wr_busy) bad++;
    end
    chk("noinit_idle", bad, 0);
    @(posedge clk_100M); #1;
    init_done = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk_100M);
      if (axi_awvalid || wr_busy) bad++;
    end
    chk("late_init_idle", bad, 0);

    run_burst("second_rise", 28'($urandom()), 4'd5, 1, 2, 1'b1, 0);
    run_burst("maxlen", 28'($urandom()), 4'd15, 2, 2, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run_burst($sformatf("rand%0d", i), 28'($urandom()), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), 2, 1'b0, 0);

    // reset mid-burst with wr_req still high, then release
    run_burst("abort", 28'($urandom()), 4'd7, 0, 0, 1'b0, 3);
    repeat (2) @(posedge clk_100M);
    #1 rstn = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk_100M);
      if (axi_awvalid || wr_busy || axi_wvalid) bad++;
    end
    chk("held_req_after_reset", bad, 0);
    run_burst("after_reset", 28'($urandom()), 4'd7, 0, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
